noc_pkt_sequencer: RTL and testbench

Sequencer that drives the NOC master's packet-memory ROM in simulation. On `start` it walks ROM addresses from `BASE_ADDR`, decodes the 8-bit control field of each 72-bit word, and streams the 64-bit payload over a valid/ready interface toward the NOC master datapath. It marks packet boundaries, optionally inserts inter-packet gaps, counts packets, and stops on an end-of-file word, on a `stop` request, or on address overrun.

---
 rtl/noc_pkt_pkg.sv | 27 ++
 rtl/noc_pkt_sequencer_if.sv | 23 ++
 rtl/noc_pkt_word_dec.sv | 22 ++
 rtl/noc_pkt_sequencer.sv | 161 ++++++++++++++++
 tb/tb_noc_pkt_sequencer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkt_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkt_pkg
// Shared definitions for the NOC packet sequencer slice: sequencer state
// encoding and the bit layout of a 72-bit packet-memory ROM word.
//   [71] EOP, [70] EOF, [69:64] GAP, [63:0] payload
// Optional feature macro: NOC_PKT_SEQ_GAP_EN (adds the GAP state).
// -----------------------------------------------------------------------------
package noc_pkt_pkg;

  localparam int EOP_BIT   = 71;
  localparam int EOF_BIT   = 70;
  localparam int GAP_MSB   = 69;
  localparam int GAP_LSB   = 64;
  localparam int PAYLOAD_W = 64;
  localparam int GAP_W     = GAP_MSB - GAP_LSB + 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
`ifdef NOC_PKT_SEQ_GAP_EN
    ST_GAP  = 3'd3,
`endif
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/noc_pkt_sequencer_if.sv
// -----------------------------------------------------------------------------
// noc_pkt_sequencer_if
// Payload stream from the sequencer toward the NOC master datapath.
//   out_valid : beat valid (master)       out_data : 64-bit payload (master)
//   out_last  : last beat of packet (master)
//   out_ready : downstream accepts (slave)
// Handshake: a beat transfers on a rising edge where out_valid and out_ready
// are both 1. Once out_valid is raised, out_data/out_last/out_valid stay
// stable until that transfer; out_valid never depends on out_ready.
// -----------------------------------------------------------------------------
interface noc_pkt_sequencer_if;
  import noc_pkt_pkg::*;

  logic                 out_valid;
  logic                 out_ready;
  logic [PAYLOAD_W-1:0] out_data;
  logic                 out_last;

  modport master (output out_valid, output out_data, output out_last,
                  input  out_ready);
  modport slave  (input  out_valid, input  out_data, input  out_last,
                  output out_ready);
endinterface

// File: rtl/noc_pkt_word_dec.sv
// -----------------------------------------------------------------------------
// noc_pkt_word_dec
// Combinational split of a ROM word into its control and payload fields.
//   i_word    : ROM word
//   o_payload : [63:0]   o_eop : [71]   o_eof : [70]   o_gap : [69:64]
// -----------------------------------------------------------------------------
module noc_pkt_word_dec
  import noc_pkt_pkg::*;
#(
  parameter int DATA_WIDTH = 72
) (
  input  logic [DATA_WIDTH-1:0] i_word,
  output logic [PAYLOAD_W-1:0]  o_payload,
  output logic                  o_eop,
  output logic                  o_eof,
  output logic [GAP_W-1:0]      o_gap
);
  assign o_payload = i_word[PAYLOAD_W-1:0];
  assign o_eop     = i_word[EOP_BIT];
  assign o_eof     = i_word[EOF_BIT];
  assign o_gap     = i_word[GAP_MSB:GAP_LSB];
endmodule

// File: rtl/noc_pkt_sequencer.sv
// -----------------------------------------------------------------------------
// noc_pkt_sequencer
// Walks the packet-memory ROM from BASE_ADDR after start, streams payloads
// over out_if, marks EOP beats, counts packets and ends on EOF, stop (at a
// packet boundary) or address overrun at DEPTH.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   start, stop    : run start (IDLE/DONE only), level stop request
//   rom_addr       : ROM address (combinational ROM)
//   rom_data       : ROM word at rom_addr, same cycle
//   out_if         : payload stream (master modport)
//   busy, done     : run in progress / run finished (held)
//   overrun        : run ended by reaching DEPTH without EOF
//   pkt_count      : EOP beats accepted this run (saturating)
//   o_dbg_state    : current FSM state
// Optional feature macro: NOC_PKT_SEQ_GAP_EN (honour the GAP field).
// -----------------------------------------------------------------------------
module noc_pkt_sequencer
  import noc_pkt_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 48,
  parameter int                    DATA_WIDTH = 72,
  parameter int                    DEPTH      = 65536,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  noc_pkt_sequencer_if.master   out_if,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic [15:0]           pkt_count,
  output state_t                o_dbg_state
);

  state_t                r_state, w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [PAYLOAD_W-1:0]  r_data;
  logic                  r_last, r_valid, r_done, r_overrun;
  logic [15:0]           r_pkt_count;

  logic [PAYLOAD_W-1:0]  w_payload;
  logic                  w_eop, w_eof;
  logic [GAP_W-1:0]      w_gap;
  logic                  w_hs, w_at_end, w_clear, w_load, w_drop, w_set_done, w_set_overrun;

`ifdef NOC_PKT_SEQ_GAP_EN
  logic [GAP_W-1:0]      r_gap;
`else
  logic                  w_unused_gap;
  assign w_unused_gap = &{1'b0, w_gap};
`endif

  noc_pkt_word_dec #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
    .i_word    (rom_data),
    .o_payload (w_payload),
    .o_eop     (w_eop),
    .o_eof     (w_eof),
    .o_gap     (w_gap)
  );

  assign w_hs     = (r_state == ST_SEND) && r_valid && out_if.out_ready;
  // r_addr already points past the beat on the bus, so DEPTH here means the
  // beat just accepted came from the last valid word.
  assign w_at_end = (r_addr == ADDR_WIDTH'(DEPTH));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: if (start) w_next_state = ST_LOAD;
      ST_LOAD:          w_next_state = w_eof ? ST_DONE : ST_SEND;
      ST_SEND: begin
        if (w_hs) begin
          if (r_last && stop)             w_next_state = ST_DONE;
          else if (w_at_end)              w_next_state = ST_DONE;
`ifdef NOC_PKT_SEQ_GAP_EN
          else if (r_last && r_gap != '0) w_next_state = ST_GAP;
`endif
          else if (w_eof)                 w_next_state = ST_DONE;
          // else: next word loads in the same cycle, stay in SEND
        end
      end
`ifdef NOC_PKT_SEQ_GAP_EN
      ST_GAP:  if (r_gap == GAP_W'(1)) w_next_state = ST_LOAD;
`endif
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output / control strobes derived from the transition being taken
  always_comb begin
    w_clear       = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
    w_load        = (w_next_state == ST_SEND) && ((r_state == ST_LOAD) || w_hs);
    w_drop        = w_hs && (w_next_state != ST_SEND);
    w_set_done    = (r_state != ST_DONE) && (w_next_state == ST_DONE);
    w_set_overrun = w_hs && (w_next_state == ST_DONE) && w_at_end && !(r_last && stop);
  end

  // Address counter, output register and run status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr      <= BASE_ADDR;
      r_data      <= '0;
      r_last      <= 1'b0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
      r_pkt_count <= '0;
`ifdef NOC_PKT_SEQ_GAP_EN
      r_gap       <= '0;
`endif
    end else begin
      if (w_clear) begin
        r_addr      <= BASE_ADDR;
        r_pkt_count <= '0;
        r_done      <= 1'b0;
        r_overrun   <= 1'b0;
      end
      if (w_load) begin
        r_data  <= w_payload;
        r_last  <= w_eop;
        r_valid <= 1'b1;
        r_addr  <= r_addr + ADDR_WIDTH'(1);
`ifdef NOC_PKT_SEQ_GAP_EN
        r_gap   <= w_gap;
`endif
      end else if (w_drop) begin
        r_valid <= 1'b0;
      end
      if (w_hs && r_last && (r_pkt_count != 16'hFFFF))
        r_pkt_count <= r_pkt_count + 16'd1;
      if (w_set_done)    r_done    <= 1'b1;
      if (w_set_overrun) r_overrun <= 1'b1;
`ifdef NOC_PKT_SEQ_GAP_EN
      if (r_state == ST_GAP) r_gap <= r_gap - GAP_W'(1);
`endif
    end
  end

  assign rom_addr         = r_addr;
  assign out_if.out_valid = r_valid;
  assign out_if.out_data  = r_data;
  assign out_if.out_last  = r_last;
  assign busy             = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done             = r_done;
  assign overrun          = r_overrun;
  assign pkt_count        = r_pkt_count;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_noc_pkt_sequencer.sv
module tb_noc_pkt_sequencer;
  import noc_pkt_pkg::*;

  localparam int AW      = 48;
  localparam int DW      = 72;
  localparam int DEPTH_A = 64;
  localparam int DEPTH_B = 16;
  localparam logic [DW-1:0] EOF_WORD = {1'b0, 1'b1, 6'd0, 64'd0};
`ifdef NOC_PKT_SEQ_GAP_EN
  localparam int EXP_BUBBLES = 6;
`else
  localparam int EXP_BUBBLES = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start_a = 1'b0, stop_a = 1'b0, start_b = 1'b0, stop_b = 1'b0;
  logic [AW-1:0] rom_addr_a, rom_addr_b;
  logic [DW-1:0] rom_data_a, rom_data_b;
  logic busy_a, done_a, over_a, busy_b, done_b, over_b;
  logic [15:0] pkt_a, pkt_b;
  state_t st_a, st_b;

  noc_pkt_sequencer_if a_if ();
  noc_pkt_sequencer_if b_if ();

  logic [DW-1:0] rom_a [DEPTH_A];
  logic [DW-1:0] rom_b [DEPTH_B];

  assign rom_data_a = (rom_addr_a < AW'(DEPTH_A)) ? rom_a[rom_addr_a[5:0]] : EOF_WORD;
  assign rom_data_b = (rom_addr_b < AW'(DEPTH_B)) ? rom_b[rom_addr_b[3:0]] : EOF_WORD;

  noc_pkt_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH_A),
                      .BASE_ADDR(48'd0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a), .out_if(a_if),
    .busy(busy_a), .done(done_a), .overrun(over_a), .pkt_count(pkt_a),
    .o_dbg_state(st_a)
  );

  noc_pkt_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH_B),
                      .BASE_ADDR(48'(DEPTH_B - 2))) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b), .out_if(b_if),
    .busy(busy_b), .done(done_b), .overrun(over_b), .pkt_count(pkt_b),
    .o_dbg_state(st_b)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic        exp_last_q[$];
  logic [63:0] got_data[$];
  logic        got_last[$];
  int          got_cyc[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc = 0;
  int          first_valid_cyc = -1;
  int          stall_viol = 0;
  int          b_beats = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;
  logic        prev_last = 1'b0;

  // Beats are observed mid-cycle; a beat seen with valid&ready here completes
  // at the following rising edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (prev_stall && (!a_if.out_valid || a_if.out_data !== prev_data ||
                       a_if.out_last !== prev_last))
      stall_viol = stall_viol + 1;
    prev_stall = a_if.out_valid && !a_if.out_ready;
    prev_data  = a_if.out_data;
    prev_last  = a_if.out_last;
    if (a_if.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (a_if.out_valid && a_if.out_ready) begin
      got_data.push_back(a_if.out_data);
      got_last.push_back(a_if.out_last);
      got_cyc.push_back(cyc);
    end
    if (b_if.out_valid && b_if.out_ready) b_beats = b_beats + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    got_data.delete(); got_last.delete(); got_cyc.delete();
    first_valid_cyc = -1; stall_viol = 0; prev_stall = 1'b0;
  endtask

  function automatic logic [DW-1:0] mkw(input logic eop, input logic eof,
                                         input logic [5:0] gap, input logic [63:0] pl);
    return {eop, eof, gap, pl};
  endfunction

  task automatic fill_eof_a();
    for (int i = 0; i < DEPTH_A; i++) rom_a[i] = EOF_WORD;
    exp_q.delete(); exp_last_q.delete();
  endtask

  // Two packets of three words, then EOF at address 6.
  task automatic img_two_pkts(input logic [7:0] tag);
    fill_eof_a();
    for (int k = 0; k < 6; k++) begin
      logic [63:0] pl;
      logic        eop;
      pl  = {8'hA5, tag, 40'h0, 8'(k)};
      eop = (k == 2) || (k == 5);
      rom_a[k] = mkw(eop, 1'b0, 6'd0, pl);
      exp_q.push_back(pl);
      exp_last_q.push_back(eop);
    end
  endtask

  task automatic start_pulse_a(output int s);
    @(posedge clk); #1; start_a = 1'b1; s = cyc;
    @(posedge clk); #1; start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, input string tag);
    int n;
    n = 0;
    while (!done_a && n < budget) begin @(posedge clk); #1; n++; end
    check({tag, "_done"}, 64'(done_a), 64'd1);
  endtask

  task automatic check_beats(input string tag);
    check({tag, "_nbeats"}, 64'(got_data.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), got_data[i], exp_q[i]);
      check($sformatf("%s_last%0d", tag, i), 64'(got_last[i]), 64'(exp_last_q[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int s;
    a_if.out_ready = 1'b1;
    b_if.out_ready = 1'b1;
    for (int i = 0; i < DEPTH_B; i++) rom_b[i] = mkw(1'b0, 1'b0, 6'd0, 64'(32'hB000 + i));
    fill_eof_a();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(a_if.out_valid), 64'd0);
    check("rst_data",  a_if.out_data, 64'd0);
    check("rst_last",  64'(a_if.out_last), 64'd0);
    check("rst_busy",  64'(busy_a), 64'd0);
    check("rst_done",  64'(done_a), 64'd0);
    check("rst_over",  64'(over_a), 64'd0);
    check("rst_pkt",   64'(pkt_a), 64'd0);
    check("rst_addr",  64'(rom_addr_a), 64'd0);
    check("rst_state", 64'(st_a), 64'(ST_IDLE));
    check("rst_addr_b", 64'(rom_addr_b), 64'(DEPTH_B - 2));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: two packets, ready held high
    img_two_pkts(8'h01);
    clear_mon();
    start_pulse_a(s);
    check("t1_busy", 64'(busy_a), 64'd1);
    wait_done_a(40, "t1");
    check_beats("t1");
    check("t1_latency", 64'(first_valid_cyc - s), 64'd3);
    if (got_cyc.size() == 6)
      check("t1_span", 64'(got_cyc[5] - first_valid_cyc + 1), 64'd6);
    check("t1_pkt",   64'(pkt_a), 64'd2);
    check("t1_over",  64'(over_a), 64'd0);
    check("t1_addr",  64'(rom_addr_a), 64'd6);
    check("t1_busy_end", 64'(busy_a), 64'd0);
    check("t1_state", 64'(st_a), 64'(ST_DONE));

    // 2: same image, ready toggling every cycle
    img_two_pkts(8'h02);
    clear_mon();
    @(posedge clk); #1; start_a = 1'b1; a_if.out_ready = 1'b0;
    @(posedge clk); #1; start_a = 1'b0; a_if.out_ready = 1'b1;
    for (int i = 0; i < 60 && !done_a; i++) begin
      @(posedge clk); #1; a_if.out_ready = ~a_if.out_ready;
    end
    a_if.out_ready = 1'b1;
    check("t2_done", 64'(done_a), 64'd1);
    check_beats("t2");
    check("t2_stall_stable", 64'(stall_viol), 64'd0);
    if (got_cyc.size() == 6)
      check("t2_span", 64'(got_cyc[5] - first_valid_cyc + 1), 64'd12);
    check("t2_pkt", 64'(pkt_a), 64'd2);

    // 3: EOP word carrying GAP=5
    fill_eof_a();
    rom_a[0] = mkw(1'b1, 1'b0, 6'd5, 64'hCAFE_0000);
    rom_a[1] = mkw(1'b1, 1'b0, 6'd0, 64'hCAFE_0001);
    exp_q.push_back(64'hCAFE_0000); exp_last_q.push_back(1'b1);
    exp_q.push_back(64'hCAFE_0001); exp_last_q.push_back(1'b1);
    clear_mon();
    start_pulse_a(s);
    wait_done_a(60, "t3");
    check_beats("t3");
    if (got_cyc.size() == 2)
      check("t3_bubbles", 64'(got_cyc[1] - got_cyc[0] - 1), 64'(EXP_BUBBLES));
    check("t3_pkt", 64'(pkt_a), 64'd2);

    // 4: stop raised during beat 2 of a 4-word packet
    fill_eof_a();
    for (int k = 0; k < 4; k++) begin
      rom_a[k] = mkw(k == 3, 1'b0, 6'd0, 64'(32'hD000 + k));
      exp_q.push_back(64'(32'hD000 + k));
      exp_last_q.push_back(k == 3);
    end
    rom_a[4] = mkw(1'b1, 1'b0, 6'd0, 64'hDEAD);
    clear_mon();
    start_pulse_a(s);
    for (int i = 0; i < 20 && got_data.size() < 1; i++) @(posedge clk);
    #1; stop_a = 1'b1;
    wait_done_a(40, "t4");
    stop_a = 1'b0;
    check_beats("t4");
    check("t4_pkt",  64'(pkt_a), 64'd1);
    check("t4_addr", 64'(rom_addr_a), 64'd4);

    // 5: base at DEPTH-2, no EOF -> overrun
    @(posedge clk); #1; start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    for (int i = 0; i < 40 && !done_b; i++) begin @(posedge clk); #1; end
    check("t5_done",  64'(done_b), 64'd1);
    check("t5_beats", 64'(b_beats), 64'd2);
    check("t5_over",  64'(over_b), 64'd1);
    check("t5_pkt",   64'(pkt_b), 64'd0);
    check("t5_addr",  64'(rom_addr_b), 64'(DEPTH_B));

    // 6: reset mid-SEND, then replay
    img_two_pkts(8'h06);
    clear_mon();
    start_pulse_a(s);
    for (int i = 0; i < 20 && got_data.size() < 4; i++) @(posedge clk);
    #1;
    check("t6_pkt_pre",   64'(pkt_a), 64'd1);
    check("t6_valid_pre", 64'(a_if.out_valid), 64'd1);
    rst_n = 1'b0; a_if.out_ready = 1'b0;
    @(posedge clk); #1;
    check("t6_valid", 64'(a_if.out_valid), 64'd0);
    check("t6_pkt",   64'(pkt_a), 64'd0);
    check("t6_busy",  64'(busy_a), 64'd0);
    check("t6_addr",  64'(rom_addr_a), 64'd0);
    check("t6_state", 64'(st_a), 64'(ST_IDLE));
    rst_n = 1'b1; a_if.out_ready = 1'b1;
    clear_mon();
    start_pulse_a(s);
    wait_done_a(40, "t6r");
    check_beats("t6r");
    check("t6r_pkt", 64'(pkt_a), 64'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
